// File: rtl/dip_histogram_if.sv
// Pixel-in / bin-readout bundle for dip_histogram.
// The pixel stream comes from the upstream DIP stage (its Rout/Gout/Bout/OKout).
// The readout side is a valid/ready stream of (bin_idx, bin_count) words.
interface dip_histogram_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       Rin;
    logic [7:0]       Gin;
    logic [7:0]       Bin;
    logic             OKin;
    logic             bin_ready;
    logic             bin_valid;
    logic [3:0]       bin_idx;
    logic [CNT_W-1:0] bin_count;

    // Pixel source and readout sink
    modport master (
        output Rin, Gin, Bin, OKin, bin_ready,
        input  bin_valid, bin_idx, bin_count
    );

    // Histogram block
    modport slave (
        input  Rin, Gin, Bin, OKin, bin_ready,
        output bin_valid, bin_idx, bin_count
    );
endinterface

// File: rtl/dip_histogram.sv
// 16-bin histogram of one pixel channel (R, G, B or luma) over a frame of
// frame_len pixels, followed by a valid/ready readout of all 16 bins.
// Optional feature macro: DIP_HIST_SATURATE_EN -- when defined, bins stick at
// all-ones instead of wrapping. The pixel counter is unaffected.
module dip_histogram #(
    parameter int CNT_W = 16
) (
    input  logic             clka,
    input  logic             reset,
    dip_histogram_if.slave   px,
    input  logic [1:0]       channel_sel,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             start,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCUM   = 2'd1;
    localparam logic [1:0] S_READOUT = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       sel_reg;
    logic [CNT_W-1:0] len_reg;
    logic [CNT_W-1:0] pix_cnt_reg;
    logic [CNT_W-1:0] pix_cnt_next;
    logic [3:0]       idx_reg;
    logic             done_reg;
    logic [CNT_W-1:0] bins_reg [16];

    logic [9:0]       luma_sum;
    logic [7:0]       sample;
    logic [3:0]       sample_bin;
    logic             start_hit;
    logic             pixel_hit;
    logic             last_pixel;
    logic             xfer;

    // Select the sample for the latched channel and derive its bin
    always_comb begin
        luma_sum = {2'b00, px.Rin} + {1'b0, px.Gin, 1'b0} + {2'b00, px.Bin};
        sample   = px.Rin;
        case (sel_reg)
            2'd0:    sample = px.Rin;
            2'd1:    sample = px.Gin;
            2'd2:    sample = px.Bin;
            default: sample = luma_sum[9:2];
        endcase
        sample_bin = sample[7:4];
    end

    assign start_hit    = (state_reg == S_IDLE) && start;
    assign pixel_hit    = (state_reg == S_ACCUM) && px.OKin;
    assign pix_cnt_next = pix_cnt_reg + 1'b1;
    assign last_pixel   = pixel_hit && (pix_cnt_next == len_reg);
    assign xfer         = (state_reg == S_READOUT) && px.bin_ready;

    // One counter per bin: cleared on reset/start, bumped by matching pixels
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bin
            logic [CNT_W-1:0] bin_inc;
`ifdef DIP_HIST_SATURATE_EN
            assign bin_inc = (&bins_reg[gi]) ? bins_reg[gi] : bins_reg[gi] + 1'b1;
`else
            assign bin_inc = bins_reg[gi] + 1'b1;
`endif
            always_ff @(posedge clka) begin
                if (reset || start_hit) begin
                    bins_reg[gi] <= '0;
                end else if (pixel_hit && (sample_bin == 4'(gi))) begin
                    bins_reg[gi] <= bin_inc;
                end
            end
        end
    endgenerate

    // Frame control: IDLE -> ACCUM -> READOUT -> IDLE, done pulse on exit
    always_ff @(posedge clka) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            sel_reg     <= 2'd0;
            len_reg     <= '0;
            pix_cnt_reg <= '0;
            idx_reg     <= 4'd0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sel_reg     <= channel_sel;
                        len_reg     <= frame_len;
                        pix_cnt_reg <= '0;
                        idx_reg     <= 4'd0;
                        state_reg   <= (frame_len == '0) ? S_READOUT : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (pixel_hit) begin
                        pix_cnt_reg <= pix_cnt_next;
                    end
                    if (last_pixel) begin
                        idx_reg   <= 4'd0;
                        state_reg <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (xfer) begin
                        idx_reg <= idx_reg + 4'd1;
                        if (idx_reg == 4'd15) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign px.bin_valid = (state_reg == S_READOUT);
    assign px.bin_idx   = idx_reg;
    assign px.bin_count = px.bin_valid ? bins_reg[idx_reg] : '0;
    assign busy         = (state_reg != S_IDLE);
    assign done         = done_reg;
endmodule

// File: tb/tb_dip_histogram.sv
// Scoreboard bench for dip_histogram: each frame's expected bin counts are
// computed from the driven pixels, queued, and compared word by word during
// readout (including stall cycles, where the head word must hold).
module tb_dip_histogram;
    localparam int CNT_W = 4;

    logic             clka = 1'b0;
    logic             reset;
    logic [1:0]       channel_sel;
    logic [CNT_W-1:0] frame_len;
    logic             start;
    logic             busy;
    logic             done;

    dip_histogram_if #(.CNT_W(CNT_W)) px ();

    dip_histogram #(.CNT_W(CNT_W)) dut (
        .clka        (clka),
        .reset       (reset),
        .px          (px),
        .channel_sel (channel_sel),
        .frame_len   (frame_len),
        .start       (start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clka = ~clka;

    typedef struct {
        int idx;
        int cnt;
    } exp_t;

    exp_t     sb[$];
    bit [7:0] p_r[$];
    bit [7:0] p_g[$];
    bit [7:0] p_b[$];
    int       n_checks = 0;
    int       n_bad    = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    function automatic int exp_bin(input logic [1:0] sel, input bit [7:0] r,
                                   input bit [7:0] g, input bit [7:0] b);
        int s;
        case (sel)
            2'd0:    s = r;
            2'd1:    s = g;
            2'd2:    s = b;
            default: s = (int'(r) + 2 * int'(g) + int'(b)) / 4;
        endcase
        return s / 16;
    endfunction

    task automatic add_px(input bit [7:0] r, input bit [7:0] g, input bit [7:0] b);
        p_r.push_back(r);
        p_g.push_back(g);
        p_b.push_back(b);
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_frame(input logic [1:0] sel, input int flen,
                             input int ready_mode, input bit poke_start);
        int  exp_bins[16];
        int  accepted = 0;
        int  cyc = 0;
        bit  r;
        bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        foreach (exp_bins[i]) exp_bins[i] = 0;

        start       = 1'b1;
        channel_sel = sel;
        frame_len   = CNT_W'(flen);
        tick();
        start       = 1'b0;
        channel_sel = ~sel;
        frame_len   = CNT_W'($urandom);
        check_val("busy_after_start", int'(busy), 1);
        check_val("valid_after_start", int'(px.bin_valid), int'(flen == 0));

        for (int i = 0; i < p_r.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                px.OKin = 1'b0;
                px.Rin  = 8'($urandom);
                px.Gin  = 8'($urandom);
                px.Bin  = 8'($urandom);
                tick();
            end
            px.OKin = 1'b1;
            px.Rin  = p_r[i];
            px.Gin  = p_g[i];
            px.Bin  = p_b[i];
            tick();
            if (accepted < flen) begin
                exp_bins[exp_bin(sel, p_r[i], p_g[i], p_b[i])]++;
                accepted++;
            end
        end
        px.OKin = 1'b0;
        p_r.delete();
        p_g.delete();
        p_b.delete();

        for (int i = 0; i < 16; i++) sb.push_back('{idx: i, cnt: exp_bins[i]});

        while (sb.size() > 0 && cyc < 300) begin
            check_val("rd_valid", int'(px.bin_valid), 1);
            check_val("rd_idx", int'(px.bin_idx), sb[0].idx);
            check_val("rd_count", int'(px.bin_count), sb[0].cnt);
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = pat[cyc % 4];
                default: r = 1'($urandom);
            endcase
            start        = poke_start && (cyc == 1);
            px.bin_ready = r;
            tick();
            if (r) void'(sb.pop_front());
            cyc++;
        end
        if (sb.size() > 0) begin
            check_val("readout_timeout", cyc, -1);
            sb.delete();
        end
        px.bin_ready = 1'b0;
        start        = 1'b0;
        check_val("done_pulse", int'(done), 1);
        check_val("valid_after_last", int'(px.bin_valid), 0);
        check_val("busy_after_last", int'(busy), 0);
        tick();
        check_val("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        channel_sel  = 2'd0;
        frame_len    = '0;
        px.Rin       = 8'd0;
        px.Gin       = 8'd0;
        px.Bin       = 8'd0;
        px.OKin      = 1'b0;
        px.bin_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_valid", int'(px.bin_valid), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_idx", int'(px.bin_idx), 0);
        check_val("rst_count", int'(px.bin_count), 0);

        // Red channel, four pixels
        add_px(8'h10, 8'h00, 8'h00);
        add_px(8'h1F, 8'h00, 8'h00);
        add_px(8'hF0, 8'h00, 8'h00);
        add_px(8'h25, 8'h00, 8'h00);
        run_frame(2'd0, 4, 0, 1'b0);

        // Luma of a single pixel
        add_px(8'h40, 8'h80, 8'hC0);
        run_frame(2'd3, 1, 1, 1'b0);

        // Zero-length frame
        run_frame(2'd0, 0, 0, 1'b0);

        // Green, stalled readout with a start poked mid-readout
        for (int i = 0; i < 12; i++) add_px(8'($urandom), 8'($urandom), 8'($urandom));
        run_frame(2'd1, 12, 1, 1'b1);

        // Pixels beyond frame_len must not be counted
        for (int i = 0; i < 17; i++) add_px(8'($urandom), 8'h00, 8'($urandom));
        run_frame(2'd1, 15, 2, 1'b0);

        // Blue and luma random frames
        for (int i = 0; i < 15; i++) add_px(8'($urandom), 8'($urandom), 8'($urandom));
        run_frame(2'd2, 15, 2, 1'b0);
        for (int i = 0; i < 15; i++) add_px(8'($urandom), 8'($urandom), 8'($urandom));
        run_frame(2'd3, 15, 0, 1'b1);

        // Reset in the middle of accumulation
        start       = 1'b1;
        channel_sel = 2'd0;
        frame_len   = CNT_W'(10);
        tick();
        start   = 1'b0;
        px.OKin = 1'b1;
        px.Rin  = 8'h55;
        tick();
        tick();
        tick();
        px.OKin = 1'b0;
        check_val("accum_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_valid", int'(px.bin_valid), 0);
        check_val("midrst_done", int'(done), 0);
        check_val("midrst_count", int'(px.bin_count), 0);
        tick();
        check_val("midrst_no_done", int'(done), 0);
        check_val("midrst_idle", int'(busy), 0);
        run_frame(2'd0, 0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/dip_histogram.md
DIP_HISTOGRAM -- requirements
Module: dip_histogram

Interface
REQ-001 Parameter CNT_W, default 16, width of each bin counter and of the frame-length/pixel counters.
REQ-002 clka  input  1  single clock for all logic; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Rin, Gin, Bin  input  8 each  pixel channels from the upstream DIP stage (its Rout/Gout/Bout).
REQ-005 OKin  input  1  pixel valid (upstream OKout); one pixel per cycle when high.
REQ-006 channel_sel  input  2  source select: 0=R, 1=G, 2=B, 3=luma.
REQ-007 frame_len  input  CNT_W  number of pixels per frame, sampled on start.
REQ-008 start  input  1  single-cycle frame start request.
REQ-009 bin_ready  input  1  downstream ready for readout.
REQ-010 bin_valid  output  1  readout word valid.
REQ-011 bin_idx  output  4  index of the bin being presented.
REQ-012 bin_count  output  CNT_W  count of bin bin_idx.
REQ-013 busy  output  1  high in ACCUM and READOUT.
REQ-014 done  output  1  one-cycle pulse after the last bin is transferred.

Function
REQ-015 FSM states: IDLE, ACCUM, READOUT; 16 bins, each CNT_W bits.
REQ-016 IDLE: start=1 clears all bins and the pixel counter, latches channel_sel and frame_len, and enters ACCUM next cycle; if the latched frame_len=0, enters READOUT instead.
REQ-017 start is ignored in ACCUM and READOUT; OKin is ignored in IDLE and READOUT.
REQ-018 Sample value: R, G, or B per latched select; luma = (Rin + 2*Gin + Bin) >> 2, computed at 10 bits, result 8 bits.
REQ-019 Bin index = sample[7:4].
REQ-020 ACCUM: each cycle with OKin=1 increments the selected bin and the pixel counter by 1; the update is visible one cycle later.
REQ-021 When the pixel counter reaches the latched frame_len on an accepted pixel, the state changes to READOUT on the next edge; that pixel is counted.
REQ-022 READOUT: bin_valid=1, bin_idx starts at 0, and bin_count = bin[bin_idx].
REQ-023 A transfer occurs on a cycle with bin_valid & bin_ready; bin_idx then increments.
REQ-024 bin_idx and bin_count hold stable while bin_valid=1 and bin_ready=0.
REQ-025 A transfer at bin_idx=15 returns the block to IDLE, drops bin_valid, and pulses done=1 for exactly that next cycle.
REQ-026 busy=1 exactly when the state is ACCUM or READOUT.
REQ-027 Bins hold their contents in IDLE until the next start.

Reset
REQ-028 reset=1 on a clock edge forces IDLE, all bins=0, pixel counter=0, bin_idx=0, bin_valid=0, bin_count=0, busy=0, done=0.
REQ-029 reset overrides every other input, including mid-ACCUM and mid-READOUT; no done pulse is generated.

Configuration
REQ-030 Macro DIP_HIST_SATURATE_EN.
- Defined: a bin at 2^CNT_W-1 holds that value on further increments.
- Undefined: bins wrap modulo 2^CNT_W.
- The pixel counter behaves the same either way.

Verification
REQ-031 start, frame_len=4, sel=0, Rin=0x10,0x1F,0xF0,0x25 with OKin=1 -> readout bin1=2, bin2=1, bin15=1, all others 0; done after 16 transfers.
REQ-032 sel=3, R=0x40, G=0x80, B=0xC0, frame_len=1 -> luma=0x80; bin8=1.
REQ-033 frame_len=0, start -> READOUT the next cycle; 16 zero counts; done pulse.
REQ-034 Toggle bin_ready 1,0,0,1 during READOUT -> bin_idx and bin_count stable while ready=0; no bins skipped or duplicated.
REQ-035 CNT_W=4, frame_len=15, 17 pixels of Gin=0 sel=1 -> bin0=15 (only 15 counted); separately, a frame of 15 with SATURATE_EN set -> bin0=15; mid-ACCUM reset -> IDLE, busy=0, all bins read 0 after the next zero-length frame.
REQ-036 start asserted during READOUT -> ignored; frame_len change during ACCUM -> no effect.
